// File: rtl/guest_sysctl.sv
// System-control block for MiST guest cores: clock-enable strobes plus a
// stretched core reset sequenced from board, config, OSD/button and download sources.
module guest_sysctl #(
  parameter int unsigned     DIV_W          = 3,
  parameter int unsigned     FAST_BITS      = 2,
  parameter int unsigned     AUX_DIV        = 6,
  parameter int unsigned     CFG_W          = 5,
  parameter logic [CFG_W-1:0] CFG_MASK      = '1,
  parameter logic [7:0]      DL_INDEX       = 8'd1,
  parameter int unsigned     STRETCH_CYCLES = 16,
  parameter int unsigned     POR_CYCLES     = 64
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [CFG_W-1:0] cfg_i,
  input  logic             osd_reset_i,
  input  logic             button_reset_i,
  input  logic             ioctl_download_i,
  input  logic [7:0]       ioctl_index_i,
  output logic             ce_fast_o,
  output logic             ce_slow_o,
  output logic             ce_aux_o,
  output logic             sys_reset_o,
  output logic [3:0]       reset_cause_o
);

  localparam int unsigned MAX_LEN = (POR_CYCLES > STRETCH_CYCLES) ? POR_CYCLES : STRETCH_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);
  localparam int unsigned AUX_W   = (AUX_DIV > 1) ? $clog2(AUX_DIV) : 1;

  localparam logic [CNT_W-1:0] POR_LEN  = CNT_W'(POR_CYCLES);
  localparam logic [CNT_W-1:0] STR_LEN  = CNT_W'(STRETCH_CYCLES);
  localparam logic [AUX_W-1:0] AUX_LAST = AUX_W'(AUX_DIV - 1);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STRETCH = 2'd1,
    RUN     = 2'd2
  } state_e;

  logic [DIV_W-1:0] div_q;
  logic [AUX_W-1:0] aux_q;
  logic             ce_fast_q, ce_slow_q, ce_aux_q;
  logic [CFG_W-1:0] cfg_q;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cause_q, cause_d;
  logic             sys_reset_q;

  logic             chg, dl, src;
  logic [3:0]       srcbits;
  logic [CNT_W-1:0] len;

  // Strobes are registered compares of the pre-increment counter value, so
  // the first post-release cycle has every strobe high.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div_q     <= '0;
      aux_q     <= '0;
      ce_fast_q <= 1'b0;
      ce_slow_q <= 1'b0;
      ce_aux_q  <= 1'b0;
    end else begin
      div_q     <= div_q + DIV_W'(1);
      ce_fast_q <= (div_q[FAST_BITS-1:0] == '0);
      ce_slow_q <= (div_q == '0);
      aux_q     <= (aux_q == AUX_LAST) ? '0 : aux_q + AUX_W'(1);
      ce_aux_q  <= (aux_q == '0);
    end
  end

  // Tracked even during reset so releasing reset never looks like a config change.
  always_ff @(posedge clk_sys) begin
    cfg_q <= cfg_i;
  end

  assign chg     = |((cfg_i ^ cfg_q) & CFG_MASK);
  assign dl      = ioctl_download_i & (ioctl_index_i == DL_INDEX);
  assign src     = chg | osd_reset_i | button_reset_i | dl;
  assign srcbits = {dl, osd_reset_i | button_reset_i, chg, 1'b0};
  assign len     = cause_q[0] ? POR_LEN : STR_LEN;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    unique case (state_q)
      HOLD: begin
        if (src) begin
          cause_d = cause_q | srcbits;
        end else if (len == '0) begin
          state_d = RUN;
        end else begin
          state_d = STRETCH;
          cnt_d   = len - CNT_W'(1);
        end
      end
      STRETCH: begin
        if (src) begin
          state_d = HOLD;
          cause_d = cause_q | srcbits;
        end else if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RUN: begin
        // A fresh reset episode records only its own causes.
        if (src) begin
          state_d = HOLD;
          cause_d = srcbits;
        end
      end
      default: begin
        state_d = HOLD;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= HOLD;
      cnt_q       <= '0;
      cause_q     <= 4'b0001;
      sys_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cause_q     <= cause_d;
      sys_reset_q <= (state_d != RUN);
    end
  end

  assign ce_fast_o     = ce_fast_q;
  assign ce_slow_o     = ce_slow_q;
  assign ce_aux_o      = ce_aux_q;
  assign sys_reset_o   = sys_reset_q;
  assign reset_cause_o = cause_q;

endmodule

// File: tb/tb_guest_sysctl.sv
// Bench for guest_sysctl: three parameter variants driven in lockstep, checked
// every cycle against an edge-counting reference model plus scenario tables.
module tb_guest_sysctl;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic            reset;
  logic [4:0]      cfg;
  logic            osd, btn, dlOn;
  logic [7:0]      dlIdx;
  logic [2:0]      ceFast, ceSlow, ceAux, sysRst;
  logic [2:0][3:0] causeOut;

  guest_sysctl dut0 (
    .clk_sys(clk_sys), .reset(reset), .cfg_i(cfg), .osd_reset_i(osd),
    .button_reset_i(btn), .ioctl_download_i(dlOn), .ioctl_index_i(dlIdx),
    .ce_fast_o(ceFast[0]), .ce_slow_o(ceSlow[0]), .ce_aux_o(ceAux[0]),
    .sys_reset_o(sysRst[0]), .reset_cause_o(causeOut[0])
  );

  guest_sysctl #(.CFG_MASK(5'b11011)) dut1 (
    .clk_sys(clk_sys), .reset(reset), .cfg_i(cfg), .osd_reset_i(osd),
    .button_reset_i(btn), .ioctl_download_i(dlOn), .ioctl_index_i(dlIdx),
    .ce_fast_o(ceFast[1]), .ce_slow_o(ceSlow[1]), .ce_aux_o(ceAux[1]),
    .sys_reset_o(sysRst[1]), .reset_cause_o(causeOut[1])
  );

  guest_sysctl #(.STRETCH_CYCLES(0)) dut2 (
    .clk_sys(clk_sys), .reset(reset), .cfg_i(cfg), .osd_reset_i(osd),
    .button_reset_i(btn), .ioctl_download_i(dlOn), .ioctl_index_i(dlIdx),
    .ce_fast_o(ceFast[2]), .ce_slow_o(ceSlow[2]), .ce_aux_o(ceAux[2]),
    .sys_reset_o(sysRst[2]), .reset_cause_o(causeOut[2])
  );

  typedef struct {
    logic [4:0] cfgXor;
    bit         cfgRevert;
    bit         osdOn;
    bit         btnOn;
    bit         useDl;
    logic [7:0] dlIndex;
    int         srcCycles;
    int         expHigh0;
    int         expHigh1;
    int         expHigh2;
    logic [3:0] expCause;
  } vec_t;

  vec_t vecs[8];

  int         total = 0;
  int         bad   = 0;
  int         highs[3];
  int         n[3];
  int         since[3];
  bit         active[3];
  logic [3:0] mCause[3];
  logic [4:0] prevCfg[3];

  function automatic logic [4:0] maskOf(int d);
    return (d == 1) ? 5'b11011 : 5'b11111;
  endfunction

  function automatic int strLen(int d);
    return (d == 2) ? 0 : 16;
  endfunction

  task automatic cmp(string name, int d, logic [3:0] act, logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s dut%0d t=%0t got=%b want=%b", name, d, $time, act, exp);
    end
  endtask

  task automatic cmpInt(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s t=%0t got=%0d want=%0d", name, $time, act, exp);
    end
  endtask

  // The model counts edges since release and since the last source edge; the
  // reset stays active until more than len edges have passed without a source.
  task automatic applyStimulus();
    @(posedge clk_sys);
    for (int d = 0; d < 3; d++) begin
      logic       chg, dlv, src;
      logic [3:0] bits;
      int         len;
      if (reset) begin
        n[d]      = 0;
        active[d] = 1'b1;
        since[d]  = 0;
        mCause[d] = 4'b0001;
      end else begin
        n[d]++;
        chg  = |((cfg ^ prevCfg[d]) & maskOf(d));
        dlv  = dlOn && (dlIdx == 8'd1);
        src  = chg | osd | btn | dlv;
        bits = {dlv, osd | btn, chg, 1'b0};
        if (src) begin
          mCause[d] = active[d] ? (mCause[d] | bits) : bits;
          active[d] = 1'b1;
          since[d]  = 0;
        end else if (active[d]) begin
          since[d]++;
          len = mCause[d][0] ? 64 : strLen(d);
          if (since[d] > len) active[d] = 1'b0;
        end
      end
      prevCfg[d] = cfg;
    end
    #1;
  endtask

  task automatic checkOutput();
    for (int d = 0; d < 3; d++) begin
      cmp("ce_fast", d, {3'b0, ceFast[d]}, {3'b0, (n[d] > 0) && ((n[d] - 1) % 4 == 0)});
      cmp("ce_slow", d, {3'b0, ceSlow[d]}, {3'b0, (n[d] > 0) && ((n[d] - 1) % 8 == 0)});
      cmp("ce_aux", d, {3'b0, ceAux[d]}, {3'b0, (n[d] > 0) && ((n[d] - 1) % 6 == 0)});
      cmp("sys_reset", d, {3'b0, sysRst[d]}, {3'b0, active[d]});
      cmp("cause", d, causeOut[d], mCause[d]);
      if (sysRst[d]) highs[d]++;
    end
  endtask

  task automatic tick();
    applyStimulus();
    checkOutput();
  endtask

  task automatic settle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (sysRst == 3'b000) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      total++;
      bad++;
      $display("[TB] FAIL settle_timeout t=%0t sys_reset=%b want=000", $time, sysRst);
    end
  endtask

  initial begin
    vecs[0] = '{5'b00100, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1,   17,  0,   1,   4'b0010};
    vecs[1] = '{5'b00100, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1,   18,  0,   2,   4'b0010};
    vecs[2] = '{5'b00000, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 100, 116, 116, 100, 4'b1000};
    vecs[3] = '{5'b00000, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 100, 0,   0,   0,   4'b1000};
    vecs[4] = '{5'b00000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1,   17,  17,  1,   4'b0100};
    vecs[5] = '{5'b00000, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1,   17,  17,  1,   4'b0100};
    vecs[6] = '{5'b00000, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1, 1,   17,  17,  1,   4'b1100};
    vecs[7] = '{5'b00001, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1,   17,  17,  1,   4'b0010};

    reset = 1'b1; cfg = 5'b0; osd = 1'b0; btn = 1'b0; dlOn = 1'b0; dlIdx = 8'd0;
    highs = '{0, 0, 0};
    repeat (3) tick();
    cmp("reset_sysrst", 0, {3'b0, sysRst[0]}, 4'b0001);
    cmp("reset_cause", 0, causeOut[0], 4'b0001);
    cmp("reset_ce", 0, {1'b0, ceFast[0], ceSlow[0], ceAux[0]}, 4'b0000);

    // Power-on release: strobes start in phase, board reset holds for POR.
    reset = 1'b0;
    highs = '{0, 0, 0};
    tick();
    cmp("release_ce", 0, {1'b0, ceFast[0], ceSlow[0], ceAux[0]}, 4'b0111);
    settle();
    for (int d = 0; d < 3; d++) cmpInt($sformatf("por_len_dut%0d", d), highs[d], 64);

    for (int v = 0; v < 8; v++) begin
      highs = '{0, 0, 0};
      for (int c = 0; c < vecs[v].srcCycles; c++) begin
        if (c == 0) cfg = cfg ^ vecs[v].cfgXor;
        osd   = vecs[v].osdOn;
        btn   = vecs[v].btnOn;
        dlOn  = vecs[v].useDl;
        dlIdx = vecs[v].dlIndex;
        tick();
      end
      if (vecs[v].cfgRevert) cfg = cfg ^ vecs[v].cfgXor;
      osd = 1'b0; btn = 1'b0; dlOn = 1'b0;
      settle();
      cmpInt($sformatf("vec%0d_high0", v), highs[0], vecs[v].expHigh0);
      cmpInt($sformatf("vec%0d_high1", v), highs[1], vecs[v].expHigh1);
      cmpInt($sformatf("vec%0d_high2", v), highs[2], vecs[v].expHigh2);
      cmp($sformatf("vec%0d_cause", v), 0, causeOut[0], vecs[v].expCause);
    end

    // OSD pulse while stretching with five cycles left restarts the stretch.
    cfg = cfg ^ 5'b00010;
    tick();
    repeat (11) tick();
    osd   = 1'b1;
    highs = '{0, 0, 0};
    tick();
    osd = 1'b0;
    settle();
    cmpInt("osd_restart_high", highs[0], 17);
    cmp("osd_restart_cause", 0, causeOut[0], 4'b0110);

    // Board reset in the middle of RUN.
    highs = '{0, 0, 0};
    reset = 1'b1;
    tick();
    cmp("midrun_ce", 0, {1'b0, ceFast[0], ceSlow[0], ceAux[0]}, 4'b0000);
    cmp("midrun_sysrst", 0, {3'b0, sysRst[0]}, 4'b0001);
    cmp("midrun_cause", 0, causeOut[0], 4'b0001);
    reset = 1'b0;
    tick();
    cmp("midrun_release_ce", 0, {1'b0, ceFast[0], ceSlow[0], ceAux[0]}, 4'b0111);
    settle();
    cmpInt("midrun_high", highs[0], 65);

    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom % 1000) == 0;
      if (($urandom % 150) == 0) cfg = 5'($urandom);
      osd   = ($urandom % 200) == 0;
      btn   = ($urandom % 200) == 0;
      dlOn  = ($urandom % 150) == 0;
      dlIdx = 8'($urandom_range(0, 2));
      tick();
    end
    reset = 1'b0; osd = 1'b0; btn = 1'b0; dlOn = 1'b0;
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
